// File: rtl/instr_encoder_if.sv
// Field-bundle handshake and instruction-memory write port of instr_encoder.
// The master drives decoded fields; the slave (encoder) returns the write stream and status.
interface instr_encoder_if #(
    parameter int CNT_W = 6
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       fmt_i;
    logic [6:0]       op_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [31:0]      imm_i;
    logic             we_o;
    logic [31:0]      addr_o;
    logic [31:0]      instr_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             err_o;
    logic [1:0]       err_code_o;

    modport master (
        output in_valid_i, fmt_i, op_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
        input  in_ready_o, we_o, addr_o, instr_o, count_o, full_o, err_o, err_code_o
    );

    modport slave (
        input  in_valid_i, fmt_i, op_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
        output in_ready_o, we_o, addr_o, instr_o, count_o, full_o, err_o, err_code_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them to
// instruction memory at sequential byte addresses.
//
// state  | meaning
// S_IDLE | ready for a bundle; illegal bundles only update the sticky error
// S_WR   | one-cycle write strobe of the registered word
// S_FULL | DEPTH words written; waits for reset or flush
module instr_encoder #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_FULL} state_t;

    state_t           state, state_nxt;
    logic             clear;
    logic             accept;
    logic [31:0]      enc_word;
    logic [1:0]       enc_err;
    logic [31:0]      ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      instr_r;
    logic             err_r;
    logic [1:0]       code_r;
    logic             ready, we, full;

    assign clear  = rst_i | flush_i;
    assign accept = bus.in_valid_i & ready;

    // Range is checked before alignment, so an out-of-range odd offset reports code 2.
    always_comb begin
        enc_word = 32'h0;
        enc_err  = 2'd0;
        case (bus.fmt_i)
            3'd0: enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
            3'd1: begin
                enc_word = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_i};
                if (!(&bus.imm_i[31:11] || ~|bus.imm_i[31:11])) enc_err = 2'd2;
            end
            3'd2: begin
                enc_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                            bus.imm_i[4:0], bus.op_i};
                if (!(&bus.imm_i[31:11] || ~|bus.imm_i[31:11])) enc_err = 2'd2;
            end
            3'd3: begin
                enc_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                            bus.imm_i[4:1], bus.imm_i[11], bus.op_i};
                if (!(&bus.imm_i[31:12] || ~|bus.imm_i[31:12])) enc_err = 2'd2;
                else if (bus.imm_i[0])                            enc_err = 2'd3;
            end
            3'd4: begin
                enc_word = {bus.imm_i[31:12], bus.rd_i, bus.op_i};
                if (|bus.imm_i[11:0]) enc_err = 2'd3;
            end
            3'd5: begin
                enc_word = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11], bus.imm_i[19:12],
                            bus.rd_i, bus.op_i};
                if (!(&bus.imm_i[31:20] || ~|bus.imm_i[31:20])) enc_err = 2'd2;
                else if (bus.imm_i[0])                            enc_err = 2'd3;
            end
            default: enc_err = 2'd1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && enc_err == 2'd0) state_nxt = S_WR;
            S_WR:    state_nxt = (count_r == CNT_W'(DEPTH - 1)) ? S_FULL : S_IDLE;
            S_FULL:  state_nxt = S_FULL;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        we    = 1'b0;
        full  = 1'b0;
        case (state)
            S_IDLE:  ready = 1'b1;
            S_WR:    we    = 1'b1;
            S_FULL:  full  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            ptr_r   <= BASE_ADDR;
            count_r <= '0;
            instr_r <= 32'h0;
            err_r   <= 1'b0;
            code_r  <= 2'd0;
        end else begin
            if (state == S_IDLE && accept) begin
                if (enc_err == 2'd0) begin
                    instr_r <= enc_word;
                end else if (!err_r) begin
                    err_r  <= 1'b1;
                    code_r <= enc_err;
                end
            end
            if (state == S_WR) begin
                ptr_r   <= ptr_r + 32'd4;
                count_r <= count_r + 1'b1;
            end
        end
    end

    assign bus.in_ready_o = ready;
    assign bus.we_o       = we;
    assign bus.full_o     = full;
    assign bus.addr_o     = ptr_r;
    assign bus.instr_o    = instr_r;
    assign bus.count_o    = count_r;
    assign bus.err_o      = err_r;
    assign bus.err_code_o = code_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases from the test plan, then random
// traffic checked every cycle against a transaction-level reference model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.CNT_W(CNT_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus.slave)
    );

    // reference model: words written, pending write, sticky error
    int          m_count = 0;
    bit          m_pending = 1'b0;
    logic [31:0] m_word = 32'h0;
    bit          m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_code(input logic [2:0] fmt, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (fmt)
            3'd0: return 2'd0;
            3'd1, 3'd2: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
            3'd3: begin
                if (s < -4096 || s > 4095) return 2'd2;
                return (s % 2 != 0) ? 2'd3 : 2'd0;
            end
            3'd4: return ((imm % 4096) != 0) ? 2'd3 : 2'd0;
            3'd5: begin
                if (s < -(1 << 20) || s >= (1 << 20)) return 2'd2;
                return (s % 2 != 0) ? 2'd3 : 2'd0;
            end
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] base_r, base_i;
        base_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        base_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        case (fmt)
            3'd0: return base_r | (32'(f7) << 25) | (32'(rd) << 7);
            3'd1: return base_i | (imm << 20);
            3'd2: return base_r | (((imm >> 5) & 32'h7f) << 25) | ((imm & 32'h1f) << 7);
            3'd3: return base_r | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25)
                         | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7);
            3'd4: return (imm & 32'hffff_f000) | (32'(rd) << 7) | 32'(op);
            default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                         | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12)
                         | (32'(rd) << 7) | 32'(op);
        endcase
    endfunction

    task automatic bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm);
        bus.fmt_i = fmt;   bus.op_i = op;     bus.funct3_i = f3; bus.funct7_i = f7;
        bus.rd_i  = rd;    bus.rs1_i = rs1;   bus.rs2_i = rs2;   bus.imm_i = imm;
    endtask

    task automatic model_edge(input bit v, input bit r, input bit f);
        logic [1:0] c;
        bit         rdy;
        rdy = !m_pending && (m_count != DEPTH);
        if (r || f) begin
            m_count = 0; m_pending = 1'b0; m_word = 32'h0; m_err = 1'b0; m_code = 2'd0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_count++;
        end else if (rdy && v) begin
            c = ref_code(bus.fmt_i, bus.imm_i);
            if (c != 2'd0) begin
                if (!m_err) begin
                    m_err  = 1'b1;
                    m_code = c;
                end
            end else begin
                m_pending = 1'b1;
                m_word = ref_enc(bus.fmt_i, bus.op_i, bus.funct3_i, bus.funct7_i,
                                 bus.rd_i, bus.rs1_i, bus.rs2_i, bus.imm_i);
            end
        end
    endtask

    task automatic compare_all();
        check("we", 32'(bus.we_o), 32'(m_pending));
        check("ready", 32'(bus.in_ready_o), 32'(!m_pending && m_count != DEPTH));
        check("addr", bus.addr_o, BASE + 32'(4 * m_count));
        check("count", 32'(bus.count_o), 32'(m_count));
        check("full", 32'(bus.full_o), 32'(m_count == DEPTH));
        check("err", 32'(bus.err_o), 32'(m_err));
        check("err_code", 32'(bus.err_code_o), 32'(m_code));
        if (m_pending) check("instr", bus.instr_o, m_word);
    endtask

    // drive at negedge, advance one clock, check outputs at the following negedge
    task automatic step(input bit v, input bit r, input bit f);
        bus.in_valid_i = v;
        rst = r;
        flush = f;
        @(posedge clk);
        model_edge(v, r, f);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
            2:       return 32'($signed($urandom_range(0, 1 << 22)) - (1 << 21)) & ~32'h1;
            default: return $urandom & 32'hffff_f000;
        endcase
    endfunction

    initial begin
        int nw;
        bus.in_valid_i = 1'b0;
        bundle(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);

        step(0, 1, 0);
        check("rst_ready", 32'(bus.in_ready_o), 32'h1);
        check("rst_addr", bus.addr_o, 32'h0);
        check("rst_instr", bus.instr_o, 32'h0);

        bundle(3'd1, 7'b0010011, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
        step(1, 0, 0);
        check("addi_we", 32'(bus.we_o), 32'h1);
        check("addi_instr", bus.instr_o, 32'h0050_0093);
        step(0, 0, 0);
        check("addi_count", 32'(bus.count_o), 32'h1);

        step(0, 0, 1);
        bundle(3'd0, 7'b0110011, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
        step(1, 0, 0);
        check("add_instr", bus.instr_o, 32'h0020_81B3);
        check("add_addr", bus.addr_o, 32'h0);
        step(0, 0, 0);
        bundle(3'd2, 7'b0100011, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8);
        step(1, 0, 0);
        check("sw_instr", bus.instr_o, 32'h0020_A423);
        check("sw_addr", bus.addr_o, 32'h4);
        step(0, 0, 0);

        step(0, 0, 1);
        bundle(3'd3, 7'b1100011, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'hffff_fffc);
        step(1, 0, 0);
        check("beq_instr", bus.instr_o, 32'hFE20_8EE3);
        step(0, 0, 0);
        bundle(3'd3, 7'b1100011, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'd3);
        step(1, 0, 0);
        check("beq_odd_we", 32'(bus.we_o), 32'h0);
        check("beq_odd_code", 32'(bus.err_code_o), 32'h3);
        check("beq_odd_addr", bus.addr_o, 32'h4);

        step(0, 0, 1);
        bundle(3'd1, 7'b0010011, 3'd0, 7'h0, 5'd2, 5'd2, 5'd0, 32'd1);
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            if (bus.we_o) begin
                check("hold_addr", bus.addr_o, 32'(4 * nw));
                nw++;
            end
        end
        check("hold_writes", 32'(nw), 32'h4);
        check("hold_full", 32'(bus.full_o), 32'h1);
        check("hold_ready", 32'(bus.in_ready_o), 32'h0);

        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        check("rst_wr_we", 32'(bus.we_o), 32'h0);
        check("rst_wr_count", 32'(bus.count_o), 32'h0);
        check("rst_wr_ready", 32'(bus.in_ready_o), 32'h1);

        bundle(3'd1, 7'b0010011, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step(1, 0, 0);
        check("imm2048_code", 32'(bus.err_code_o), 32'h2);
        bundle(3'd1, 7'b0010011, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd7);
        step(1, 0, 0);
        check("after_err_we", 32'(bus.we_o), 32'h1);
        step(0, 0, 0);
        check("err_sticky", 32'(bus.err_o), 32'h1);
        step(0, 0, 1);
        check("flush_err", 32'(bus.err_o), 32'h0);

        for (int i = 0; i < 2000; i++) begin
            bundle(($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
                   7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), rand_imm());
            step($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder. Takes decoded instruction fields (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and packs them into a 32-bit RV32I instruction word.
- Streams each encoded word into instruction memory at a sequential byte address.
- Used by the testbench loader and the self-test program generator to build instruction memory images without hand-assembled hex.

Parameters:
- DEPTH, 32, number of instruction words the block may write before reporting full.
- BASE_ADDR, 32'h0000_0000, byte address of the first write.
- CNT_W, $clog2(DEPTH+1), width of count_o.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  synchronous clear of pointer, count and error; same effect as rst_i.
- in_valid_i  input  1  field bundle valid.
- in_ready_o  output  1  block can accept a bundle.
- fmt_i  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6 and 7 illegal.
- op_i  input  7  opcode field.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field (R only).
- rd_i, rs1_i, rs2_i  input  5 each  register indices.
- imm_i  input  32  signed immediate, byte offset for B/J.
- we_o  output  1  instruction-memory write strobe.
- addr_o  output  32  write byte address.
- instr_o  output  32  encoded instruction.
- count_o  output  CNT_W  words written.
- full_o  output  1  count_o == DEPTH.
- err_o  output  1  sticky encoding error.
- err_code_o  output  2  0=none, 1=illegal fmt, 2=imm out of range, 3=imm misaligned.

Behaviour:
- Reset and flush: all outputs go to 0 except in_ready_o=1 and addr_o=BASE_ADDR. State goes to S_IDLE.
- Reset has priority over every other event. A handshake in the same cycle as rst_i or flush_i is discarded.
- FSM states:
  - S_IDLE: in_ready_o=1. On accept with a legal bundle, go to S_WR. On accept with an illegal bundle, set err_o/err_code_o, no write, stay in S_IDLE.
  - S_WR: in_ready_o=0, we_o=1 for exactly one cycle. Then increment the pointer and count, and go to S_FULL if count reaches DEPTH, otherwise S_IDLE.
  - S_FULL: in_ready_o=0, full_o=1. Held until rst_i or flush_i.
- Latency and throughput:
  - Bundle accepted at edge N → we_o/instr_o/addr_o valid in the cycle after edge N (registered).
  - Maximum throughput is 1 word per 2 cycles.
- Addressing: addr_o advances by 4 after each write. count_o increments by 1 after each write. Neither advances on an error.
- Errors:
  - err_o is sticky; a later legal bundle does not clear it.
  - err_code_o records the first error only.
  - Accepts continue after an error.
- Encoding, in bit order MSB→LSB:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Fields unused by a format are ignored.
- Range checks:
  - I/S: imm[31:11] all equal, else code 2.
  - B: imm[31:12] all equal, else code 2; imm[0]=0, else code 3.
  - J: imm[31:20] all equal, else code 2; imm[0]=0, else code 3.
  - U: imm[11:0]=0, else code 3.
  - Range is checked before alignment.
- Handshake: in_valid_i may drop without being accepted. Input fields are sampled only on accept.

Test Plan:
- Reset, then I fmt, op=0010011, f3=0, rd=1, rs1=0, imm=5 → one cycle later we_o=1, addr_o=0, instr_o=0x00500093; count_o=1 afterwards.
- R fmt, op=0110011, f3=0, f7=0, rd=3, rs1=1, rs2=2, then S fmt, op=0100011, f3=2, rs1=1, rs2=2, imm=8 → 0x002081B3 at addr 0, then 0x0020A423 at addr 4.
- B fmt, op=1100011, f3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3. Then B with imm=3 → no we_o, err_o=1, err_code_o=3, addr_o unchanged.
- DEPTH=4: hold in_valid_i high with legal bundles → writes at 0, 4, 8, 12. Then full_o=1, in_ready_o=0, and no 5th we_o.
- Assert rst_i in the S_WR cycle → next cycle we_o=0, count_o=0, addr_o=0, in_ready_o=1.
- I fmt with imm=2048 → err_code_o=2. A following legal bundle is written normally and err_o stays 1 until flush_i.
